// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory stage: FSM encoding, stage record and byte-lane helpers.
package mem_stage_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } mem_state_e;

    typedef struct packed {
        logic        dmem_we;
        logic        reg_we;
        logic        s_byte;
        logic        s_wrd;
        logic [4:0]  wra;
        logic [31:0] rd2;
        logic [31:0] alu_out;
    } stage_t;

    function automatic logic [3:0] byte_be(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

    function automatic logic [31:0] sext_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and sign-extended load extraction.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic        i_sByte,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rd2,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    always_comb begin
        o_be    = i_sByte ? byte_be(i_offset) : 4'b1111;
        o_wdata = i_sByte ? {4{i_rd2[7:0]}} : i_rd2;
        o_load  = i_sByte ? sext_byte(i_rdata, i_offset) : i_rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: stage register, IDLE/ACCESS handshake FSM with timeout, write-back regs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_MEM_dmemWe,
    input  logic        i_MEM_regWe,
    input  logic        i_MEM_sByte,
    input  logic        i_MEM_sWRD,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_rd2,
    input  logic [31:0] i_MEM_aluOut,
    output logic        o_MEM_dmReq,
    output logic        o_MEM_dmWe,
    output logic [31:0] o_MEM_dmAddr,
    output logic [3:0]  o_MEM_dmBe,
    output logic [31:0] o_MEM_dmWdata,
    input  logic [31:0] i_MEM_dmRdata,
    input  logic        i_MEM_dmAck,
    output logic        o_MEM_pause,
    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_wd,
    output logic        o_MEM_err
);

    mem_state_e  r_state, w_state_d;
    stage_t      r_s, w_s_in;
    logic [7:0]  r_cnt, w_cnt_d;
    logic        w_access, w_timeout, w_pause;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;

    mem_lane_align u_lane (
        .i_sByte  (r_s.s_byte),
        .i_offset (r_s.alu_out[1:0]),
        .i_rd2    (r_s.rd2),
        .i_rdata  (i_MEM_dmRdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_load   (w_load)
    );

    always_comb begin
        w_s_in = '{dmem_we: i_MEM_dmemWe, reg_we: i_MEM_regWe, s_byte: i_MEM_sByte,
                   s_wrd: i_MEM_sWRD, wra: i_MEM_WRA, rd2: i_MEM_rd2, alu_out: i_MEM_aluOut};
        w_access  = (r_state == StAccess);
        // Ack in the final wait cycle takes priority over the abort.
        w_timeout = w_access & (r_cnt == 8'(WAIT_LIMIT - 1)) & ~i_MEM_dmAck;
        w_pause   = w_access & ~i_MEM_dmAck & ~w_timeout;

        w_state_d = r_state;
        w_cnt_d   = r_cnt + 8'd1;
        if (!w_pause) begin
            w_state_d = (i_MEM_dmemWe | i_MEM_sWRD) ? StAccess : StIdle;
            w_cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_s         <= '0;
            r_cnt       <= 8'd0;
            o_MEM_regWe <= 1'b0;
            o_MEM_WRA   <= 5'd0;
            o_MEM_wd    <= 32'd0;
            o_MEM_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (!w_pause) begin
                r_s         <= w_s_in;
                o_MEM_regWe <= r_s.reg_we & ~w_timeout;
                o_MEM_WRA   <= r_s.wra;
                o_MEM_wd    <= r_s.s_wrd ? w_load : r_s.alu_out;
            end
            if (w_timeout) o_MEM_err <= 1'b1;
        end
    end

    // Byte enables are only meaningful alongside a request, so they stay quiet in IDLE.
    always_comb begin
        o_MEM_dmReq   = w_access;
        o_MEM_dmWe    = r_s.dmem_we;
        o_MEM_dmAddr  = {r_s.alu_out[31:2], 2'b00};
        o_MEM_dmBe    = w_access ? w_be : 4'b0000;
        o_MEM_dmWdata = w_wdata;
        o_MEM_pause   = w_pause;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (WAIT_LIMIT = 4 to exercise the timeout path).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmemWe, regWe, sByte, sWRD;
    logic [4:0]  wra;
    logic [31:0] rd2, aluOut, rdata;
    logic        ack;
    logic        dmReq, dmWe, pause, o_regWe, err;
    logic [31:0] dmAddr, dmWdata, wd;
    logic [3:0]  dmBe;
    logic [4:0]  o_wra;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_LIMIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_MEM_dmemWe  (dmemWe),
        .i_MEM_regWe   (regWe),
        .i_MEM_sByte   (sByte),
        .i_MEM_sWRD    (sWRD),
        .i_MEM_WRA     (wra),
        .i_MEM_rd2     (rd2),
        .i_MEM_aluOut  (aluOut),
        .o_MEM_dmReq   (dmReq),
        .o_MEM_dmWe    (dmWe),
        .o_MEM_dmAddr  (dmAddr),
        .o_MEM_dmBe    (dmBe),
        .o_MEM_dmWdata (dmWdata),
        .i_MEM_dmRdata (rdata),
        .i_MEM_dmAck   (ack),
        .o_MEM_pause   (pause),
        .o_MEM_regWe   (o_regWe),
        .o_MEM_WRA     (o_wra),
        .o_MEM_wd      (wd),
        .o_MEM_err     (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic we, input logic rwe, input logic sb, input logic swrd,
                          input logic [4:0] a, input logic [31:0] d, input logic [31:0] alu);
        dmemWe = we; regWe = rwe; sByte = sb; sWRD = swrd; wra = a; rd2 = d; aluOut = alu;
    endtask

    task automatic bubble();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        bubble(); ack = 1'b0; rdata = 32'd0; rst = 1'b1;
        step(); step();
        rst = 1'b0; #1;
        n_checks++;
        if ({dmReq, pause, o_regWe, err} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {dmReq, pause, o_regWe, err});
        else n_pass++;
        n_checks++;
        if ({o_wra, wd, dmBe} !== 41'd0) $display("FAIL reset_wb: got %h/%h/%h want 0", o_wra, wd, dmBe);
        else n_pass++;
    endtask

    task automatic test_alu();
        bit req_seen = 0;
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'd0, 32'h12345678);
        step(); req_seen |= dmReq;
        bubble();
        step(); req_seen |= dmReq;
        n_checks++;
        if ({o_regWe, o_wra, wd} !== {1'b1, 5'd5, 32'h12345678})
            $display("FAIL alu_wb: got %b/%0d/%h want 1/5/12345678", o_regWe, o_wra, wd);
        else n_pass++;
        n_checks++;
        if (req_seen !== 1'b0) $display("FAIL alu_noreq: got dmReq %b want 0", req_seen);
        else n_pass++;
    endtask

    // Ack arrives in the last wait cycle, which also hits the timeout count: ack must win.
    task automatic test_lw();
        int pcnt = 0;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'd0, 32'h100);
        step(); bubble();
        for (int i = 0; i < 3; i++) begin
            if (pause === 1'b1) pcnt++;
            step();
        end
        n_checks++;
        if ({dmReq, dmWe, dmAddr, dmBe} !== {1'b1, 1'b0, 32'h100, 4'hF})
            $display("FAIL lw_req: got %b/%b/%h/%h want 1/0/100/f", dmReq, dmWe, dmAddr, dmBe);
        else n_pass++;
        ack = 1'b1; rdata = 32'hDEADBEEF; #1;
        n_checks++;
        if (pause !== 1'b0) $display("FAIL lw_ack_pause: got %b want 0", pause);
        else n_pass++;
        step(); ack = 1'b0; rdata = 32'd0; #1;
        n_checks++;
        if (pcnt !== 3) $display("FAIL lw_pause_cycles: got %0d want 3", pcnt);
        else n_pass++;
        n_checks++;
        if ({o_regWe, o_wra, wd, err, dmReq} !== {1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0})
            $display("FAIL lw_wb: got %b/%0d/%h err %b req %b want 1/7/deadbeef err 0 req 0",
                     o_regWe, o_wra, wd, err, dmReq);
        else n_pass++;
    endtask

    task automatic test_byte();
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd0, 32'h103);
        step(); bubble();
        n_checks++;
        if ({dmBe, dmAddr} !== {4'h8, 32'h100}) $display("FAIL lb_be: got %h/%h want 8/100", dmBe, dmAddr);
        else n_pass++;
        ack = 1'b1; rdata = 32'h80FF0011;
        step(); ack = 1'b0; #1;
        n_checks++;
        if ({o_regWe, wd} !== {1'b1, 32'hFFFFFF80}) $display("FAIL lb_wd: got %b/%h want 1/ffffff80", o_regWe, wd);
        else n_pass++;
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h000000AB, 32'h101);
        step(); bubble();
        n_checks++;
        if ({dmWe, dmBe, dmWdata} !== {1'b1, 4'h2, 32'hABABABAB})
            $display("FAIL sb_req: got %b/%h/%h want 1/2/abababab", dmWe, dmBe, dmWdata);
        else n_pass++;
        ack = 1'b1;
        step(); ack = 1'b0; #1;
        n_checks++;
        if (o_regWe !== 1'b0) $display("FAIL sb_regwe: got %b want 0", o_regWe);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int pcnt = 0;
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'd0, 32'h200);
        step(); bubble();
        while (pause === 1'b1 && pcnt < 10) begin
            pcnt++;
            step();
        end
        n_checks++;
        if (pcnt !== 3) $display("FAIL to_pause_cycles: got %0d want 3", pcnt);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL to_err_early: got %b want 0", err);
        else n_pass++;
        step();
        n_checks++;
        if ({err, o_regWe, dmReq} !== 3'b100)
            $display("FAIL to_abort: got err/regWe/req %b want 100", {err, o_regWe, dmReq});
        else n_pass++;
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'd0, 32'h55);
        step(); bubble();
        step();
        n_checks++;
        if ({o_regWe, o_wra, wd, err} !== {1'b1, 5'd1, 32'h55, 1'b1})
            $display("FAIL to_resume: got %b/%0d/%h err %b want 1/1/55 err 1", o_regWe, o_wra, wd, err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit pause_seen = 0;
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h11111111, 32'h300);
        step();
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h22222222, 32'h304);
        ack = 1'b1; #1;
        pause_seen |= pause;
        n_checks++;
        if ({dmReq, dmAddr, dmWdata} !== {1'b1, 32'h300, 32'h11111111})
            $display("FAIL b2b_first: got %b/%h/%h want 1/300/11111111", dmReq, dmAddr, dmWdata);
        else n_pass++;
        step(); bubble(); #1;
        pause_seen |= pause;
        n_checks++;
        if ({dmReq, dmAddr, dmWdata} !== {1'b1, 32'h304, 32'h22222222})
            $display("FAIL b2b_second: got %b/%h/%h want 1/304/22222222", dmReq, dmAddr, dmWdata);
        else n_pass++;
        step(); ack = 1'b0; #1;
        n_checks++;
        if ({pause_seen, dmReq} !== 2'b00) $display("FAIL b2b_end: got pause/req %b want 00", {pause_seen, dmReq});
        else n_pass++;
    endtask

    task automatic test_reset_in_access();
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'd0, 32'h400);
        step(); bubble();
        step();
        n_checks++;
        if (dmReq !== 1'b1) $display("FAIL rsta_req_before: got %b want 1", dmReq);
        else n_pass++;
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        n_checks++;
        if ({dmReq, pause, err, o_regWe, o_wra, wd} !== 41'd0)
            $display("FAIL rsta_cleared: got %b%b%b%b/%0d/%h want all 0", dmReq, pause, err, o_regWe, o_wra, wd);
        else n_pass++;
        ack = 1'b1; rdata = 32'hCAFEF00D;
        step(); ack = 1'b0; #1;
        n_checks++;
        if ({dmReq, pause, err, o_regWe, o_wra, wd} !== 41'd0)
            $display("FAIL rsta_late_ack: got %b%b%b%b/%0d/%h want all 0", dmReq, pause, err, o_regWe, o_wra, wd);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_byte();
        test_timeout();
        test_back_to_back();
        test_reset_in_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
